// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready input and output channels; MUL (and DIVU/REMU
// when ALU_MC_DIV_EN is defined) run W-iteration loops, other ops take one cycle.
`timescale 1ns/1ps
module alu_mc #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [4:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000, OP_SUB   = 5'b00001, OP_MUL   = 5'b00010, OP_DIVU  = 5'b00011,
    OP_SLL   = 5'b00100, OP_SRL   = 5'b00101, OP_ROL   = 5'b00110, OP_ROR   = 5'b00111,
    OP_AND   = 5'b01000, OP_OR    = 5'b01001, OP_XOR   = 5'b01010, OP_NOR   = 5'b01011,
    OP_NAND  = 5'b01100, OP_SLTU  = 5'b01101, OP_SLT   = 5'b01110, OP_SRA   = 5'b01111,
    OP_SEXTB = 5'b10000, OP_SEXTH = 5'b10001, OP_ZEXTB = 5'b10010, OP_ZEXTH = 5'b10011,
    OP_REMU  = 5'b10100
  } op_t;

  state_t        state, state_next;
  logic          accept, start_mul, start_div, last_iter, alu_err;
  logic [W-1:0]  op_a, op_b, acc, alu_res, mul_acc_next;
  logic [SW-1:0] cnt, sh, sh_neg;

  assign accept       = in_valid && in_ready;
  assign start_mul    = (sel == OP_MUL);
  assign last_iter    = (cnt == SW'(W - 1));
  assign sh           = b[SW-1:0];
  // W - sh modulo W; a zero rotate then ORs the operand with itself.
  assign sh_neg       = -sh;
  assign mul_acc_next = acc + (op_b[0] ? op_a : '0);

`ifdef ALU_MC_DIV_EN
  // Restoring divide: acc is the partial remainder, op_a shifts the dividend
  // out and the quotient in, op_b holds the divisor.
  logic         is_rem, div_ge;
  logic [W:0]   div_trial;
  logic [W-1:0] rem_next, quo_next, div_res;

  assign start_div = ((sel == OP_DIVU) || (sel == OP_REMU)) && (b != '0);
  assign div_trial = {acc, op_a[W-1]} - {1'b0, op_b};
  assign div_ge    = !div_trial[W];
  assign rem_next  = div_ge ? div_trial[W-1:0] : {acc[W-2:0], op_a[W-1]};
  assign quo_next  = {op_a[W-2:0], div_ge};
  assign div_res   = is_rem ? rem_next : quo_next;
`else
  assign start_div = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    alu_res = '0;
    alu_err = 1'b0;
    case (sel)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_MUL:   alu_res = '0;
      OP_SLL:   alu_res = a << sh;
      OP_SRL:   alu_res = a >> sh;
      OP_ROL:   alu_res = (a << sh) | (a >> sh_neg);
      OP_ROR:   alu_res = (a >> sh) | (a << sh_neg);
      OP_SRA:   alu_res = $signed(a) >>> sh;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOR:   alu_res = ~(a | b);
      OP_NAND:  alu_res = ~(a & b);
      OP_SLTU:  alu_res = {{(W-1){1'b0}}, (a < b)};
      OP_SLT:   alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SEXTB: alu_res = {{(W-8){a[7]}}, a[7:0]};
      OP_SEXTH: alu_res = {{(W-16){a[15]}}, a[15:0]};
      OP_ZEXTB: alu_res = {{(W-8){1'b0}}, a[7:0]};
      OP_ZEXTH: alu_res = {{(W-16){1'b0}}, a[15:0]};
`ifdef ALU_MC_DIV_EN
      // Only reached with b == 0; nonzero divisors take the iterative path.
      OP_DIVU:  alu_res = '1;
      OP_REMU:  alu_res = a;
`else
      OP_DIVU:  alu_err = 1'b1;
      OP_REMU:  alu_err = 1'b1;
`endif
      default:  alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) begin
        if (start_mul)      state_next = S_MUL;
        else if (start_div) state_next = S_DIV;
        else                state_next = S_DONE;
      end
      S_MUL:  if (last_iter) state_next = S_DONE;
`ifdef ALU_MC_DIV_EN
      S_DIV:  if (last_iter) state_next = S_DONE;
`endif
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well, so a reset mid-operation leaves no stale result visible.
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_rem <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_a <= a;
          op_b <= b;
          acc  <= '0;
          cnt  <= '0;
`ifdef ALU_MC_DIV_EN
          is_rem <= (sel == OP_REMU);
`endif
          if (!start_mul && !start_div) begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            err    <= alu_err;
          end
        end
        S_MUL: begin
          acc  <= mul_acc_next;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            result <= mul_acc_next;
            zero   <= (mul_acc_next == '0);
            err    <= 1'b0;
          end
        end
`ifdef ALU_MC_DIV_EN
        S_DIV: begin
          acc  <= rem_next;
          op_a <= quo_next;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            result <= div_res;
            zero   <= (div_res == '0);
            err    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected entries are queued at issue and
// popped when out_valid appears; result, zero, err and latency are compared.
`timescale 1ns/1ps
module tb_alu_mc;

  localparam int W    = 32;
  localparam int LONG = W + 1;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
    OP_DIVU = 5'b00011, OP_REMU = 5'b10100, OP_SLL = 5'b00100, OP_SRL = 5'b00101,
    OP_ROL = 5'b00110, OP_ROR = 5'b00111, OP_SRA = 5'b01111, OP_AND = 5'b01000,
    OP_OR = 5'b01001, OP_XOR = 5'b01010, OP_NOR = 5'b01011, OP_NAND = 5'b01100,
    OP_SLTU = 5'b01101, OP_SLT = 5'b01110, OP_SEXTB = 5'b10000, OP_SEXTH = 5'b10001,
    OP_ZEXTB = 5'b10010, OP_ZEXTH = 5'b10011;

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0]   sel = '0;
  logic         in_ready, out_valid, zero, err, busy;
  logic [W-1:0] result;

  alu_mc #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           lat;
    string        name;
  } exp_t;

  typedef struct {
    string        name;
    logic [4:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic exp_t mk(string n, logic [W-1:0] res, logic er, int lat);
    exp_t e;
    e.name = n; e.res = res; e.zero = (res == '0); e.err = er; e.lat = lat;
    return e;
  endfunction

  function automatic vec_t vec(string n, logic [4:0] s, logic [W-1:0] av, logic [W-1:0] bv,
                               logic [W-1:0] res, logic er, int lat);
    vec_t v;
    v.name = n; v.sel = s; v.a = av; v.b = bv; v.res = res; v.err = er; v.lat = lat;
    return v;
  endfunction

  // Reference model built on language operators and bit-loop rotates.
  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic [4:0] sv);
    logic [W-1:0] r = '0;
    logic [W-1:0] t;
    logic         e = 1'b0;
    int           lat = 1;
    int           s = int'(bv[4:0]);
    case (sv)
      OP_ADD:   r = av + bv;
      OP_SUB:   r = av - bv;
      OP_MUL:   begin r = av * bv; lat = LONG; end
`ifdef ALU_MC_DIV_EN
      OP_DIVU:  if (bv == '0) r = '1; else begin r = av / bv; lat = LONG; end
      OP_REMU:  if (bv == '0) r = av; else begin r = av % bv; lat = LONG; end
`else
      OP_DIVU:  e = 1'b1;
      OP_REMU:  e = 1'b1;
`endif
      OP_SLL:   r = av << s;
      OP_SRL:   r = av >> s;
      OP_ROL:   begin t = av; repeat (s) t = {t[W-2:0], t[W-1]}; r = t; end
      OP_ROR:   begin t = av; repeat (s) t = {t[0], t[W-1:1]}; r = t; end
      OP_SRA:   r = W'($signed(av) >>> s);
      OP_AND:   r = av & bv;
      OP_OR:    r = av | bv;
      OP_XOR:   r = av ^ bv;
      OP_NOR:   r = ~(av | bv);
      OP_NAND:  r = ~(av & bv);
      OP_SLTU:  r = (av < bv) ? 1 : 0;
      OP_SLT:   r = ($signed(av) < $signed(bv)) ? 1 : 0;
      OP_SEXTB: r = {{24{av[7]}}, av[7:0]};
      OP_SEXTH: r = {{16{av[15]}}, av[15:0]};
      OP_ZEXTB: r = {24'h0, av[7:0]};
      OP_ZEXTH: r = {16'h0, av[15:0]};
      default:  e = 1'b1;
    endcase
    return mk($sformatf("rand_op%0d", sv), r, e, lat);
  endfunction

  task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [4:0] sv, input exp_t e);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL %s accept: in_ready=%b after %0d cycles, want 1", e.name, in_ready, n);
    end
    a = av; b = bv; sel = sv; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sel = 5'($urandom);
  endtask

  // Called #1 after the accept edge; latency counts that edge as 1.
  task automatic wait_result(output logic [W-1:0] r, output logic z, output logic er,
                             output int lat, output bit busy_ok, output exp_t e);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (!busy || in_ready) busy_ok = 1'b0;
    r = result; z = zero; er = err;
    if (sb.size() > 0) e = sb.pop_front();
    else e = mk("empty_scoreboard", 'x, 1'bx, -1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, zero, err, busy} !== 5'b0 || result !== '0)
      $display("FAIL reset_held: rdy/ov/z/e/busy=%b result=%h, want 00000 and 0",
               {in_ready, out_valid, zero, err, busy}, result);
    else passes++;
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
               in_ready, busy, out_valid);
    else passes++;
  endtask

  task automatic run_table_checks(input vec_t tv[$]);
    logic [W-1:0] r; logic z, er; int lat; bit bok; exp_t e;
    foreach (tv[i]) begin
      send_op(tv[i].a, tv[i].b, tv[i].sel, mk(tv[i].name, tv[i].res, tv[i].err, tv[i].lat));
      wait_result(r, z, er, lat, bok, e);
      checks++; if (r !== e.res) $display("FAIL %s result: got %h want %h", e.name, r, e.res); else passes++;
      checks++; if (z !== e.zero) $display("FAIL %s zero: got %b want %b", e.name, z, e.zero); else passes++;
      checks++; if (er !== e.err) $display("FAIL %s err: got %b want %b", e.name, er, e.err); else passes++;
      checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
      checks++; if (!bok) $display("FAIL %s busy: busy/in_ready wrong while in flight, want busy=1 in_ready=0", e.name); else passes++;
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", e.name, out_valid, in_ready);
      else passes++;
    end
  endtask

  task automatic test_arith();
    vec_t tv[$];
    tv.push_back(vec("add_5_3",   OP_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1));
    tv.push_back(vec("sub_5_5",   OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1));
    tv.push_back(vec("sub_wrap",  OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1));
    tv.push_back(vec("mul_2_3",   OP_MUL, 32'd2, 32'd3, 32'd6, 1'b0, LONG));
    tv.push_back(vec("mul_max_2", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, LONG));
    tv.push_back(vec("mul_by_0",  OP_MUL, 32'h1234_5678, 32'd0, 32'd0, 1'b0, LONG));
    run_table_checks(tv);
  endtask

  task automatic test_div();
    vec_t tv[$];
`ifdef ALU_MC_DIV_EN
    tv.push_back(vec("divu_6_2",  OP_DIVU, 32'd6, 32'd2, 32'd3, 1'b0, LONG));
    tv.push_back(vec("remu_7_2",  OP_REMU, 32'd7, 32'd2, 32'd1, 1'b0, LONG));
    tv.push_back(vec("divu_9_0",  OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1));
    tv.push_back(vec("remu_9_0",  OP_REMU, 32'd9, 32'd0, 32'd9, 1'b0, 1));
    tv.push_back(vec("divu_big",  OP_DIVU, 32'hFFFF_FFFF, 32'd7, 32'h2492_4924, 1'b0, LONG));
    tv.push_back(vec("remu_big",  OP_REMU, 32'hFFFF_FFFF, 32'd7, 32'd3, 1'b0, LONG));
`else
    tv.push_back(vec("divu_off",  OP_DIVU, 32'd6, 32'd2, 32'd0, 1'b1, 1));
    tv.push_back(vec("remu_off",  OP_REMU, 32'd7, 32'd2, 32'd0, 1'b1, 1));
    tv.push_back(vec("divu0_off", OP_DIVU, 32'd9, 32'd0, 32'd0, 1'b1, 1));
`endif
    run_table_checks(tv);
  endtask

  task automatic test_shift_logic();
    vec_t tv[$];
    tv.push_back(vec("sra_m8_2",   OP_SRA,   32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFE, 1'b0, 1));
    tv.push_back(vec("ror_msb_1",  OP_ROR,   32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1));
    tv.push_back(vec("rol_4",      OP_ROL,   32'h8000_0001, 32'd4, 32'h0000_0018, 1'b0, 1));
    tv.push_back(vec("rol_mask0",  OP_ROL,   32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1));
    tv.push_back(vec("sll_31",     OP_SLL,   32'd1, 32'd31, 32'h8000_0000, 1'b0, 1));
    tv.push_back(vec("srl_mask31", OP_SRL,   32'h8000_0000, 32'd63, 32'd1, 1'b0, 1));
    tv.push_back(vec("sextb",      OP_SEXTB, 32'hBF3D_D6B5, 32'd0, 32'hFFFF_FFB5, 1'b0, 1));
    tv.push_back(vec("sexth",      OP_SEXTH, 32'h0000_8001, 32'd0, 32'hFFFF_8001, 1'b0, 1));
    tv.push_back(vec("zextb",      OP_ZEXTB, 32'hBF3D_D6B5, 32'd0, 32'h0000_00B5, 1'b0, 1));
    tv.push_back(vec("zexth",      OP_ZEXTH, 32'hBF3D_D6B5, 32'd0, 32'h0000_D6B5, 1'b0, 1));
    tv.push_back(vec("slt_m1_1",   OP_SLT,   32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1));
    tv.push_back(vec("sltu_max_1", OP_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1));
    tv.push_back(vec("nor_0_0",    OP_NOR,   32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1));
    tv.push_back(vec("nand_ones",  OP_NAND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1));
    tv.push_back(vec("illegal_31", 5'b11111, 32'h1111_2222, 32'h3333_4444, 32'd0, 1'b1, 1));
    run_table_checks(tv);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; logic z, er; int lat; bit bok; exp_t e; bit stable = 1'b1;
    send_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_XOR, mk("xor_bp", 32'hFFFF_FFFF, 1'b0, 1));
    wait_result(r, z, er, lat, bok, e);
    checks++; if (r !== e.res) $display("FAIL %s result: got %h want %h", e.name, r, e.res); else passes++;
    checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== e.res || zero !== e.zero || err !== e.err) stable = 1'b0;
    end
    checks++;
    if (!stable) $display("FAIL xor_bp hold: out_valid=%b in_ready=%b result=%h, want 1 0 %h",
                          out_valid, in_ready, result, e.res);
    else passes++;
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL xor_bp release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passes++;
  endtask

  // A request held on in_valid during a MUL must neither disturb it nor be lost.
  task automatic test_back_to_back();
    logic [W-1:0] r; logic z, er; int lat; bit bok; exp_t e;
    send_op(32'd3, 32'd4, OP_MUL, mk("mul_3_4_held", 32'd12, 1'b0, LONG));
    a = 32'd100; b = 32'd1; sel = OP_ADD; in_valid = 1'b1;
    sb.push_back(mk("held_add", 32'd101, 1'b0, 1));
    wait_result(r, z, er, lat, bok, e);
    checks++; if (r !== e.res) $display("FAIL %s result: got %h want %h", e.name, r, e.res); else passes++;
    checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
    consume();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(r, z, er, lat, bok, e);
    checks++; if (r !== e.res) $display("FAIL %s result: got %h want %h", e.name, r, e.res); else passes++;
    checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
    consume();
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r; logic z, er; int lat; bit bok; exp_t e; bit stale = 1'b0;
    send_op(32'd2, 32'd3, OP_MUL, mk("mul_aborted", 32'd6, 1'b0, LONG));
    repeat (9) @(posedge clk); #1;
    rst = 1'b1; #1;
    sb.delete();
    checks++;
    if ({in_ready, out_valid, zero, err, busy} !== 5'b0 || result !== '0)
      $display("FAIL mid_reset: rdy/ov/z/e/busy=%b result=%h, want 00000 and 0",
               {in_ready, out_valid, zero, err, busy}, result);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy || !in_ready) stale = 1'b1;
    end
    checks++;
    if (stale) $display("FAIL mid_reset_idle: out_valid/busy seen or in_ready low, want idle (ov=%b busy=%b rdy=%b)",
                        out_valid, busy, in_ready);
    else passes++;
    send_op(32'd1, 32'd1, OP_ADD, mk("add_after_reset", 32'd2, 1'b0, 1));
    wait_result(r, z, er, lat, bok, e);
    checks++; if (r !== e.res) $display("FAIL %s result: got %h want %h", e.name, r, e.res); else passes++;
    checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
    consume();
  endtask

  task automatic test_random();
    logic [W-1:0] r, av, bv; logic z, er; int lat; bit bok; exp_t e; logic [4:0] sv;
    for (int i = 0; i < 16; i++) begin
      sv = 5'($urandom_range(0, 31));
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      send_op(av, bv, sv, model(av, bv, sv));
      wait_result(r, z, er, lat, bok, e);
      checks++; if (r !== e.res) $display("FAIL %s result: a=%h b=%h got %h want %h", e.name, av, bv, r, e.res); else passes++;
      checks++; if (er !== e.err) $display("FAIL %s err: got %b want %b", e.name, er, e.err); else passes++;
      checks++; if (lat != e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); else passes++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++; if (z !== e.zero || result !== e.res) $display("FAIL %s hold: zero=%b result=%h want %b %h", e.name, zero, result, e.zero, e.res); else passes++;
      consume();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_div();
    test_shift_logic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V PE, the handshaked successor to the single-cycle `alu`. It accepts one operation at a time over a valid/ready input channel. Logic, shift and extend operations are registered in one cycle. MUL, DIVU and REMU run as iterative shift-add / restoring-divide loops. The result is held on a valid/ready output channel until consumed, so the PE pipeline can stall on long operations.

## Interface
- `W`, 32, datapath width; power of two, ≥16.
- `SW`, $clog2(W), shift-amount width (derived; do not override).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `sel`  in  5  opcode.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  W  result.
- `zero`  out  1  result == 0.
- `err`  out  1  illegal/unsupported opcode.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Opcodes:
  - 00000 ADD; 00001 SUB; 00010 MUL (low W bits); 00011 DIVU; 10100 REMU.
  - 00100 SLL; 00101 SRL; 00110 ROL; 00111 ROR; 01111 SRA. All shifts and rotates use `b[SW-1:0]`.
  - 01000 AND; 01001 OR; 01010 XOR; 01011 NOR; 01100 NAND.
  - 01101 SLTU; 01110 SLT (signed). Both return 1 or 0.
  - 10000 sign-extend `a[7:0]`; 10001 sign-extend `a[15:0]`; 10010 zero-extend `a[7:0]`; 10011 zero-extend `a[15:0]`.
  - Any other code: `result`=0, `err`=1.
- Operands and opcode are captured on the accept cycle (`in_valid && in_ready`). Later input changes are ignored until the next accept.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accept of a single-cycle op, illegal op, or DIVU/REMU with `b`=0.
  - IDLE → MUL on accept of MUL.
  - IDLE → DIV on accept of DIVU/REMU with `b`≠0.
  - MUL → DONE after W iterations; each iteration: if multiplier LSB set, add multiplicand to accumulator; shift multiplicand left, multiplier right.
  - DIV → DONE after W restoring iterations; quotient and remainder registers hold W bits each.
  - DONE → IDLE when `out_ready`=1.
- Divide by zero (RISC-V semantics): DIVU returns all ones, REMU returns `a`, `err`=0.
- All arithmetic is modulo 2^W. MUL discards the upper W bits.
- `zero` and `err` are registered together with `result`.

## Timing
- Reset values: `in_ready`=0 while `rst` asserted, then 1 (IDLE); `out_valid`=0, `result`=0, `zero`=0, `err`=0, `busy`=0.
- Latency is measured from the accept edge to `out_valid` high:
  - single-cycle, illegal, or divide-by-zero: 1 cycle;
  - MUL, DIVU, REMU: W+1 cycles.
- `out_valid` stays high, and `result`/`zero`/`err` stay stable, until a cycle with `out_ready`=1. Back-pressure is unlimited.
- `in_ready` is low from the cycle after accept until the cycle after the output handshake. There is no back-to-back overlap, so throughput is at most one op per 2 cycles.
- `in_valid` while `in_ready`=0 is ignored; the requester must hold it.
- `rst` asserted mid-operation: go to IDLE immediately. Partial state is discarded, outputs return to reset values, and no result is emitted.

## Configuration
- `ALU_MC_DIV_EN` defined: iterative divider built; DIVU/REMU behave as above.
- Not defined: divider logic omitted. DIVU/REMU take the 1-cycle path with `result`=0 and `err`=1 (treated as illegal). MUL is unaffected.

## Test plan
- ADD `a`=5, `b`=3 with `out_ready`=1 → `out_valid` 1 cycle after accept, `result`=8, `zero`=0; SUB 5−5 → `result`=0, `zero`=1.
- MUL `a`=2, `b`=3, W=32 → `out_valid` 33 cycles after accept, `result`=6, `busy`=1 throughout; MUL 0xFFFFFFFF×2 → 0xFFFFFFFE.
- DIVU 6/2 → `result`=3 after 33 cycles; REMU 7/2 → `result`=1. DIVU 9/0 → 0xFFFFFFFF after 1 cycle; REMU 9/0 → 9. Without `ALU_MC_DIV_EN`, DIVU 6/2 → `result`=0, `err`=1 after 1 cycle.
- SRA `a`=−8, `b`=2 → 0xFFFFFFFE; ROR `a`=0x80000000, `b`=1 → 0x40000000; sign-extend byte of 0xBF3DD6B5 → 0xFFFFFFB5; zero-extend half of 0xBF3DD6B5 → 0x0000D6B5; opcode 11111 → `result`=0, `err`=1.
- Back-pressure: XOR 0xF0F0F0F0 ^ 0x0F0F0F0F with `out_ready`=0 for 10 cycles → 0xFFFFFFFF held stable, `in_ready`=0 throughout; released 1 cycle after `out_ready` pulses.
- Assert `rst` at cycle 10 of a MUL → all outputs at reset values immediately, IDLE after release, no stale `out_valid`; the next ADD 1+1 → 2.
